// File: rtl/frame_pkg.sv
// Shared types, default parameters and addressing helper for the cube frame receiver.
package frame_pkg;

    // Default frame geometry: 16x16x16 LEDs, three 8-bit colour channels each
    localparam int unsigned DEF_FRAME_BYTES = 12288;
    localparam int unsigned DEF_ADDR_W      = 14;
    localparam logic [7:0]  DEF_SYNC_BYTE   = 8'hA5;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned CUBE_DIM = 16;
    localparam int unsigned COLOURS  = 3;

    // Receive state machine
    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2,
        PENDING = 2'd3
    } state_t;

    // Byte address of one colour channel of one LED inside a frame
    function automatic logic [DEF_ADDR_W-1:0] led_byte_addr(
        input logic [3:0] row,
        input logic [3:0] col,
        input logic [3:0] layer,
        input logic [1:0] colour
    );
        logic [31:0] a;
        a = ((32'(row) * CUBE_DIM + 32'(col)) * CUBE_DIM + 32'(layer)) * COLOURS
            + 32'(colour);
        return DEF_ADDR_W'(a);
    endfunction

endpackage

// File: rtl/frame_bank_ram.sv
// Two-bank frame store: one write port, one registered read port.
// The top address bit selects the bank; the rest is the byte offset in the frame.
module frame_bank_ram
    import frame_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = DEF_FRAME_BYTES,
    parameter int unsigned ADDR_W      = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W:0]   rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned WORDS = 2 * FRAME_BYTES;
    localparam int unsigned IDX_W = $clog2(WORDS);

    logic [DATA_W-1:0] mem [WORDS];

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    // Bank 1 is packed directly after bank 0 so the array holds exactly two frames
    function automatic logic [IDX_W-1:0] phys_idx(input logic [ADDR_W:0] a);
        logic [IDX_W-1:0] off;
        off = IDX_W'(a[ADDR_W-1:0]);
        if (a[ADDR_W]) begin
            return off + IDX_W'(FRAME_BYTES);
        end
        return off;
    endfunction

    // Map bank/offset addresses to physical word indices
    always_comb begin
        wr_idx = phys_idx(wr_addr);
        rd_idx = phys_idx(rd_addr);
    end

    // Write port; contents are deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Registered read port, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/frame_receiver.sv
// Host byte-stream receiver: hunts for the sync byte, stores the payload in the back
// bank, verifies the 8-bit checksum and swaps banks only on a refresh boundary.
module frame_receiver
    import frame_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = DEF_FRAME_BYTES,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter logic [7:0]  SYNC_BYTE   = DEF_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              frame_boundary,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              display_bank,
    output logic              frame_accepted,
    output logic              checksum_error
);

    state_t state;
    state_t next_state;

    logic [ADDR_W-1:0] wr_ptr;
    logic [DATA_W-1:0] sum;

    logic              rx_fire;
    logic              is_sync;
    logic              last_byte;
    logic              sum_match;
    logic              swap;

    logic              wr_en;
    logic [ADDR_W:0]   wr_addr;
    logic [ADDR_W:0]   ram_rd_addr;

    // Handshake and frame-position decodes
    always_comb begin
        rx_fire   = rx_valid & rx_ready;
        is_sync   = (rx_data == SYNC_BYTE);
        last_byte = (wr_ptr == ADDR_W'(FRAME_BYTES - 1));
        sum_match = (rx_data == sum);
        swap      = (state == PENDING) & frame_boundary;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HUNT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            HUNT: begin
                if (rx_fire && is_sync) begin
                    next_state = PAYLOAD;
                end
            end
            PAYLOAD: begin
                // Sync bytes inside the payload are ordinary data
                if (rx_fire && last_byte) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                if (rx_fire) begin
                    next_state = sum_match ? PENDING : HUNT;
                end
            end
            PENDING: begin
                if (frame_boundary) begin
                    next_state = HUNT;
                end
            end
            default: begin
                next_state = HUNT;
            end
        endcase
    end

    // State-decoded outputs: back-pressure only while a good frame waits for its swap
    always_comb begin
        rx_ready = 1'b1;
        if (state == PENDING) begin
            rx_ready = 1'b0;
        end
    end

    // Payload write pointer and running checksum
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            sum    <= '0;
        end else if (state == HUNT && rx_fire && is_sync) begin
            wr_ptr <= '0;
            sum    <= '0;
        end else if (state == PAYLOAD && rx_fire) begin
            sum <= sum + rx_data;
            // Pointer parks on the last byte instead of running past the frame
            if (!last_byte) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // Checksum verdict pulses, one cycle after the checksum byte
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_accepted <= 1'b0;
            checksum_error <= 1'b0;
        end else begin
            frame_accepted <= (state == CHECK) & rx_fire & sum_match;
            checksum_error <= (state == CHECK) & rx_fire & ~sum_match;
        end
    end

    // Front/back bank selection, toggled only on a refresh boundary with a frame waiting
    always_ff @(posedge clk) begin
        if (reset) begin
            display_bank <= 1'b0;
        end else if (swap) begin
            display_bank <= ~display_bank;
        end
    end

    // Writes always go to the back bank, reads always come from the front bank
    always_comb begin
        wr_en       = (state == PAYLOAD) & rx_fire;
        wr_addr     = {~display_bank, wr_ptr};
        ram_rd_addr = {display_bank, rd_addr};
    end

    frame_bank_ram #(
        .FRAME_BYTES (FRAME_BYTES),
        .ADDR_W      (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (rx_data),
        .rd_addr (ram_rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_frame_receiver.sv
// Randomized self-checking bench for frame_receiver with a frame-level reference model.
module tb_frame_receiver;

    localparam int N  = 12288;
    localparam int AW = 14;
    localparam logic [7:0] SYNC = 8'hA5;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          frame_boundary;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          display_bank;
    logic          frame_accepted;
    logic          checksum_error;

    int total = 0;
    int bad   = 0;
    int rd_fix = -1;
    int acc_seen = 0;
    int err_seen = 0;

    logic [7:0] pay [N];

    // Reference model state
    bit         m_live = 1'b0;
    bit         m_db;
    bit         m_pend;
    int         m_pos;          // -1 hunting, 0..N-1 payload index, N expecting checksum
    logic [7:0] m_sum;
    bit         m_acc;
    bit         m_err;
    logic [7:0] m_rd;
    bit         m_rd_known;
    logic [7:0] mbank  [2][N];
    bit         mknown [2][N];

    frame_receiver dut (
        .clk            (clk),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .frame_boundary (frame_boundary),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .display_bank   (display_bank),
        .frame_accepted (frame_accepted),
        .checksum_error (checksum_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances on each clock edge from the inputs the DUT sees
    always @(posedge clk) begin
        if (reset) begin
            m_live = 1'b1;
            m_db = 1'b0; m_pend = 1'b0; m_pos = -1; m_sum = 8'h00;
            m_acc = 1'b0; m_err = 1'b0; m_rd = 8'h00; m_rd_known = 1'b1;
        end else if (m_live) begin
            m_rd       = mbank[m_db][rd_addr];
            m_rd_known = mknown[m_db][rd_addr];
            m_acc = 1'b0;
            m_err = 1'b0;
            if (m_pend) begin
                if (frame_boundary) begin
                    m_db   = ~m_db;
                    m_pend = 1'b0;
                end
            end else if (rx_valid) begin
                if (m_pos < 0) begin
                    if (rx_data == SYNC) begin
                        m_pos = 0;
                        m_sum = 8'h00;
                    end
                end else if (m_pos < N) begin
                    mbank[~m_db][m_pos]  = rx_data;
                    mknown[~m_db][m_pos] = 1'b1;
                    m_sum = m_sum + rx_data;
                    m_pos++;
                end else begin
                    if (rx_data == m_sum) begin
                        m_acc  = 1'b1;
                        m_pend = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                    m_pos = -1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (m_live) begin
            chk("rx_ready", 16'(rx_ready), 16'(!m_pend));
            chk("display_bank", 16'(display_bank), 16'(m_db));
            chk("frame_accepted", 16'(frame_accepted), 16'(m_acc));
            chk("checksum_error", 16'(checksum_error), 16'(m_err));
            if (m_rd_known) chk("rd_data", 16'(rd_data), 16'(m_rd));
        end
        if (frame_accepted) acc_seen++;
        if (checksum_error) err_seen++;
    end

    // Read address driver: random front-bank reads unless a fixed address is requested
    always @(negedge clk) begin
        if (rd_fix >= 0) rd_addr = AW'(rd_fix);
        else             rd_addr = AW'($urandom_range(0, N - 1));
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic pulse_boundary();
        frame_boundary = 1'b1;
        cyc();
        frame_boundary = 1'b0;
    endtask

    // Present one byte until consumed; gap_pct inserts random idle cycles first
    task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit bnd);
        int waited;
        waited = 0;
        while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
            rx_valid = 1'b0;
            cyc();
        end
        rx_data  = b;
        rx_valid = 1'b1;
        frame_boundary = bnd;
        while (!rx_ready) begin
            waited++;
            if (waited > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout: rx_ready stuck at %0b, expected 1", rx_ready);
                break;
            end
            cyc();
        end
        cyc();
        rx_valid = 1'b0;
        frame_boundary = 1'b0;
    endtask

    // kind 0: payload byte i = i[7:0]; kind 1: random bytes with embedded sync values
    task automatic send_frame(input int kind, input bit bad_ck, input int gap_pct,
                              input bit bnd_on_ck, input int stop_at);
        int s;
        logic [7:0] ck;
        s = 0;
        for (int i = 0; i < N; i++) begin
            if (kind == 0) pay[i] = 8'(i);
            else           pay[i] = 8'($urandom_range(0, 255));
        end
        if (kind == 1) begin
            pay[0] = SYNC; pay[1] = SYNC; pay[100] = SYNC; pay[N-1] = SYNC;
        end
        for (int i = 0; i < N; i++) s += int'(pay[i]);
        ck = 8'(s);
        if (bad_ck) ck = ck + 8'd1;
        send_byte(SYNC, gap_pct, 1'b0);
        for (int i = 0; i < N; i++) begin
            if (stop_at >= 0 && i == stop_at) return;
            send_byte(pay[i], gap_pct, 1'b0);
        end
        send_byte(ck, gap_pct, bnd_on_ck);
    endtask

    task automatic read_at(input int a, input logic [7:0] exp, input string name);
        rd_fix = a;
        repeat (3) cyc();
        chk(name, 16'(rd_data), 16'(exp));
        rd_fix = -1;
    endtask

    initial begin
        reset = 1'b1;
        rx_data = 8'h00;
        rx_valid = 1'b0;
        frame_boundary = 1'b0;
        repeat (3) cyc();
        chk("reset_rd_data", 16'(rd_data), 16'h0000);
        reset = 1'b0;

        // Reset state with a few reads
        for (int a = 0; a < 4; a++) begin
            rd_fix = a;
            cyc();
            chk("t1_display_bank", 16'(display_bank), 16'h0);
            chk("t1_rx_ready", 16'(rx_ready), 16'h1);
            chk("t1_pulses", 16'({frame_accepted, checksum_error}), 16'h0);
        end
        rd_fix = -1;

        // Incrementing frame, correct checksum, swap on boundary
        send_frame(0, 1'b0, 0, 1'b0, -1);
        chk("t2_accept_pulse", 16'(frame_accepted), 16'h1);
        chk("t2_ready_low", 16'(rx_ready), 16'h0);
        repeat (5) cyc();
        chk("t2_wait_ready", 16'(rx_ready), 16'h0);
        chk("t2_wait_bank", 16'(display_bank), 16'h0);
        pulse_boundary();
        chk("t2_bank_swapped", 16'(display_bank), 16'h1);
        chk("t2_ready_back", 16'(rx_ready), 16'h1);
        read_at(300, 8'h2C, "t2_rd_300");
        chk("t2_accept_count", 16'(acc_seen), 16'd1);

        // Same frame with corrupted checksum
        send_frame(0, 1'b1, 0, 1'b0, -1);
        chk("t3_error_pulse", 16'(checksum_error), 16'h1);
        chk("t3_no_accept", 16'(frame_accepted), 16'h0);
        chk("t3_ready", 16'(rx_ready), 16'h1);
        cyc();
        chk("t3_bank_kept", 16'(display_bank), 16'h1);
        chk("t3_error_count", 16'(err_seen), 16'd1);

        // Leading junk, then a frame with sync values in the payload
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'hFF, 0, 1'b0);
        send_byte(8'h5A, 0, 1'b0);
        send_frame(1, 1'b0, 0, 1'b0, -1);
        chk("t4_accept_pulse", 16'(frame_accepted), 16'h1);
        cyc();
        pulse_boundary();
        chk("t4_bank", 16'(display_bank), 16'h0);
        read_at(100, SYNC, "t4_rd_sync_100");
        read_at(N - 1, SYNC, "t4_rd_sync_last");

        // Boundary coincident with checksum byte is ignored; 30% valid gaps
        send_frame(1, 1'b0, 30, 1'b1, -1);
        chk("t5_accept_pulse", 16'(frame_accepted), 16'h1);
        chk("t5_no_swap", 16'(display_bank), 16'h0);
        repeat (100) cyc();
        chk("t5_still_pending", 16'(rx_ready), 16'h0);
        pulse_boundary();
        chk("t5_bank", 16'(display_bank), 16'h1);
        read_at(N - 1, SYNC, "t5_rd_sync_last");

        // Reset in the middle of a frame, then a full frame
        send_frame(1, 1'b0, 0, 1'b0, 5000);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t6_bank_reset", 16'(display_bank), 16'h0);
        chk("t6_ready_reset", 16'(rx_ready), 16'h1);
        send_frame(1, 1'b0, 0, 1'b0, -1);
        chk("t6_accept_pulse", 16'(frame_accepted), 16'h1);
        cyc();
        pulse_boundary();
        chk("t6_bank", 16'(display_bank), 16'h1);
        read_at(7, pay[7], "t6_rd_7");
        chk("t6_accept_count", 16'(acc_seen), 16'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global cycle budget
    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: cycle budget of 95000 exhausted, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
